// File: rtl/t06_multi_apple_manager.sv
// Apple slot manager for the snake game: respawns eaten apples on free cells
// (random tries, then a linear scan) and publishes them on a divided body tick.
module t06_multi_apple_manager #(
  parameter int          NUM_APPLES = 4,
  parameter int          MAX_LENGTH = 30,
  parameter int          NUM_WALLS  = 25,
  parameter int          MAX_TRIES  = 16,
  parameter int          UPDATE_DIV = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    system_clk,
  input  logic                    reset,
  input  logic                    clk_body,
  input  logic [2:0]              apple_count,
  input  logic [NUM_APPLES-1:0]   good_collision,
  input  logic [4:0]              snake_len,
  input  logic [MAX_LENGTH*4-1:0] snakeArrayX,
  input  logic [MAX_LENGTH*4-1:0] snakeArrayY,
  input  logic [NUM_WALLS*8-1:0]  wall_locations,
  input  logic [3:0]              xmin,
  input  logic [3:0]              xmax,
  input  logic [3:0]              ymin,
  input  logic [3:0]              ymax,
  input  logic [3:0]              x,
  input  logic [3:0]              y,
  output logic                    apple,
  output logic [NUM_APPLES*8-1:0] apple_locations,
  output logic [NUM_APPLES-1:0]   apple_valid,
  output logic                    busy,
  output logic                    place_fail
);

  localparam int IDX_W = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_CHECK,
    S_SCAN,
    S_COMMIT,
    S_FAIL
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [7:0]              cand_q, cand_d;
  logic [7:0]              tries_q, tries_d;
  logic [7:0]              scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]        srv_q, srv_d;
  logic [NUM_APPLES-1:0]   pend_q, pend_d;
  logic [NUM_APPLES-1:0]   sv_q, sv_d;
  logic [NUM_APPLES-1:0]   en_q;
  logic [7:0]              shadow_q [NUM_APPLES];
  logic [7:0]              shadow_d [NUM_APPLES];
  logic [7:0]              vis_loc_q [NUM_APPLES];
  logic [7:0]              vis_loc_d [NUM_APPLES];
  logic [NUM_APPLES-1:0]   vis_valid_q, vis_valid_d;
  logic [3:0]              div_q, div_d;

  logic [3:0]              count_eff;
  logic [NUM_APPLES-1:0]   en;
  logic [NUM_APPLES-1:0]   req;
  logic [IDX_W-1:0]        pick_idx;
  logic                    cand_legal;

  // Slots at or above the (clamped) apple count are disabled.
  always_comb begin
    count_eff = ({1'b0, apple_count} > 4'(NUM_APPLES)) ? 4'(NUM_APPLES) : {1'b0, apple_count};
    for (int i = 0; i < NUM_APPLES; i++) begin
      en[i] = (4'(i) < count_eff);
    end
  end

  assign req = pend_q & en;

  always_comb begin
    pick_idx = '0;
    for (int i = NUM_APPLES - 1; i >= 0; i--) begin
      if (req[i]) pick_idx = IDX_W'(i);
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cand_legal = (cand_q[3:0] >= xmin) && (cand_q[3:0] <= xmax) &&
                 (cand_q[7:4] >= ymin) && (cand_q[7:4] <= ymax);
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if ((5'(i) < snake_len) &&
          (snakeArrayX[4*i +: 4] == cand_q[3:0]) &&
          (snakeArrayY[4*i +: 4] == cand_q[7:4])) begin
        cand_legal = 1'b0;
      end
    end
    for (int j = 0; j < NUM_WALLS; j++) begin
      if (wall_locations[8*j +: 8] == cand_q) cand_legal = 1'b0;
    end
    for (int k = 0; k < NUM_APPLES; k++) begin
      if (sv_q[k] && (IDX_W'(k) != srv_q) && (shadow_q[k] == cand_q)) cand_legal = 1'b0;
    end
  end

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Placement FSM: random candidates first, then a wrapping linear scan.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    tries_d    = tries_q;
    scan_cnt_d = scan_cnt_q;
    srv_d      = srv_q;
    sv_d       = sv_q;
    shadow_d   = shadow_q;
    pend_d     = pend_q | (good_collision & en) | (en & ~en_q);

    if ((state_q != S_IDLE) && !en[srv_q]) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|req) begin
            state_d = S_PICK;
            srv_d   = pick_idx;
            tries_d = 8'd0;
          end
        end
        S_PICK: begin
          cand_d  = lfsr_q[7:0];
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (cand_legal) begin
            state_d = S_COMMIT;
          end else begin
            tries_d = tries_q + 8'd1;
            if (tries_q + 8'd1 == 8'(MAX_TRIES)) begin
              state_d    = S_SCAN;
              scan_cnt_d = 8'd0;
            end else begin
              state_d = S_PICK;
            end
          end
        end
        S_SCAN: begin
          if (cand_legal) begin
            state_d = S_COMMIT;
          end else if (scan_cnt_q == 8'd255) begin
            state_d = S_FAIL;
          end else begin
            cand_d     = cand_q + 8'd1;
            scan_cnt_d = scan_cnt_q + 8'd1;
          end
        end
        S_COMMIT: begin
          shadow_d[srv_q] = cand_q;
          sv_d[srv_q]     = 1'b1;
          pend_d[srv_q]   = 1'b0;
          state_d         = S_IDLE;
        end
        S_FAIL: begin
          sv_d[srv_q]   = 1'b0;
          pend_d[srv_q] = 1'b0;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    pend_d = pend_d & en;
    sv_d   = sv_d & en;
  end

  // Renderer only sees the shadow copy once every UPDATE_DIV body strobes.
  always_comb begin
    div_d       = div_q;
    vis_loc_d   = vis_loc_q;
    vis_valid_d = vis_valid_q;
    if (clk_body) begin
      if (div_q == 4'(UPDATE_DIV - 1)) begin
        div_d = 4'd0;
        for (int i = 0; i < NUM_APPLES; i++) begin
          vis_loc_d[i]   = en[i] ? shadow_q[i] : 8'h00;
          vis_valid_d[i] = en[i] & sv_q[i];
        end
      end else begin
        div_d = div_q + 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      cand_q      <= 8'h00;
      tries_q     <= 8'd0;
      scan_cnt_q  <= 8'd0;
      srv_q       <= '0;
      pend_q      <= en;
      sv_q        <= '0;
      en_q        <= en;
      vis_valid_q <= '0;
      div_q       <= 4'd0;
      // NOTE: the slot arrays are a handful of flops, not RAM, so they are reset like any register.
      shadow_q    <= '{default: 8'h00};
      vis_loc_q   <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cand_q      <= cand_d;
      tries_q     <= tries_d;
      scan_cnt_q  <= scan_cnt_d;
      srv_q       <= srv_d;
      pend_q      <= pend_d;
      sv_q        <= sv_d;
      en_q        <= en;
      vis_valid_q <= vis_valid_d;
      div_q       <= div_d;
      shadow_q    <= shadow_d;
      vis_loc_q   <= vis_loc_d;
    end
  end

  always_comb begin
    apple = 1'b0;
    for (int i = 0; i < NUM_APPLES; i++) begin
      apple_locations[8*i +: 8] = vis_loc_q[i];
      if (vis_valid_q[i] && ({y, x} == vis_loc_q[i])) apple = 1'b1;
    end
  end

  assign apple_valid = vis_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign place_fail  = (state_q == S_FAIL);

endmodule

// File: tb/tb_t06_multi_apple_manager.sv
// Directed bench for t06_multi_apple_manager: placement, scan fallback, failure,
// multi-slot ordering, slot disable mid-service and reset during a scan.
module tb_t06_multi_apple_manager;

  localparam int NA = 4;
  localparam int ML = 30;
  localparam int NW = 25;
  localparam int MT = 16;
  localparam int SLOT_BUDGET = 2 * MT + 257 + 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            clk_body;
  logic [2:0]      apple_count;
  logic [NA-1:0]   gc;
  logic [4:0]      snake_len;
  logic [3:0]      sx [ML];
  logic [3:0]      sy [ML];
  logic [7:0]      walls [NW];
  logic [ML*4-1:0] snake_x_bus, snake_y_bus;
  logic [NW*8-1:0] wall_bus;
  logic [3:0]      xmin, xmax, ymin, ymax, qx, qy;
  logic            apple;
  logic [NA*8-1:0] apple_locations;
  logic [NA-1:0]   apple_valid;
  logic            busy;
  logic            place_fail;

  int n_cmp = 0;
  int n_err = 0;

  t06_multi_apple_manager dut (
    .system_clk      (clk),
    .reset           (reset),
    .clk_body        (clk_body),
    .apple_count     (apple_count),
    .good_collision  (gc),
    .snake_len       (snake_len),
    .snakeArrayX     (snake_x_bus),
    .snakeArrayY     (snake_y_bus),
    .wall_locations  (wall_bus),
    .xmin            (xmin),
    .xmax            (xmax),
    .ymin            (ymin),
    .ymax            (ymax),
    .x               (qx),
    .y               (qy),
    .apple           (apple),
    .apple_locations (apple_locations),
    .apple_valid     (apple_valid),
    .busy            (busy),
    .place_fail      (place_fail)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < ML; i++) begin
      snake_x_bus[4*i +: 4] = sx[i];
      snake_y_bus[4*i +: 4] = sy[i];
    end
    for (int j = 0; j < NW; j++) begin
      wall_bus[8*j +: 8] = walls[j];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] loc(input int i);
    return apple_locations[8*i +: 8];
  endfunction

  // Independent occupancy model built from the bench's own stimulus.
  function automatic logic legal_model(input logic [7:0] c);
    logic ok;
    ok = (c[3:0] >= xmin) && (c[3:0] <= xmax) && (c[7:4] >= ymin) && (c[7:4] <= ymax);
    for (int i = 0; i < ML; i++) begin
      if ((i < int'(snake_len)) && (sx[i] == c[3:0]) && (sy[i] == c[7:4])) ok = 1'b0;
    end
    for (int j = 0; j < NW; j++) begin
      if (walls[j] == c) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic pulse_body(input int n);
    clk_body = 1'b1;
    repeat (n) @(negedge clk);
    clk_body = 1'b0;
  endtask

  task automatic eat(input logic [NA-1:0] m);
    gc = m;
    @(negedge clk);
    gc = '0;
  endtask

  task automatic query(input logic [7:0] c, output logic a);
    qx = c[3:0];
    qy = c[7:4];
    #1;
    a = apple;
  endtask

  // Waits for one slot's service to start and end; returns place_fail pulses seen.
  task automatic wait_slot(input string tag, output int fails);
    int n;
    fails = 0;
    n = 0;
    while (busy !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy !== 1'b0 && n < SLOT_BUDGET) begin
      if (place_fail === 1'b1) fails++;
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic       a;
    int         f, f2, hits, dups;
    logic [7:0] old [NA];
    logic [7:0] cur [NA];

    reset = 1'b1; clk_body = 1'b0; gc = '0; apple_count = 3'd1; snake_len = 5'd0;
    xmin = 4'd0; xmax = 4'd15; ymin = 4'd0; ymax = 4'd15; qx = 4'd0; qy = 4'd0;
    for (int i = 0; i < ML; i++) begin sx[i] = 4'd0; sy[i] = 4'd0; end
    for (int j = 0; j < NW; j++) walls[j] = 8'hFF;
    repeat (2) @(negedge clk);

    check("rst_valid", 32'(apple_valid), 32'h0);
    check("rst_locs", apple_locations, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fail", {31'd0, place_fail}, 32'd0);
    reset = 1'b0;

    // 1: first candidate after reset is lfsr step(ACE1)=59C3 -> cell C3.
    wait_slot("t1", f);
    check("t1_nofail", f, 0);
    pulse_body(2);
    check("t1_not_yet", 32'(apple_valid), 32'h0);
    pulse_body(1);
    check("t1_valid", 32'(apple_valid), 32'h1);
    check("t1_loc", 32'(loc(0)), 32'hC3);
    query(8'hC3, a); check("t1_apple_hit", {31'd0, a}, 32'd1);
    query(8'h3C, a); check("t1_apple_miss", {31'd0, a}, 32'd0);
    query(8'hD3, a); check("t1_apple_miss2", {31'd0, a}, 32'd0);

    // 2: single legal cell 0x55.
    xmin = 4'd5; xmax = 4'd5; ymin = 4'd5; ymax = 4'd5;
    eat(4'b0001);
    wait_slot("t2", f);
    check("t2_nofail", f, 0);
    pulse_body(3);
    check("t2_loc", 32'(loc(0)), 32'h55);
    check("t2_valid", 32'(apple_valid), 32'h1);
    query(8'h55, a); check("t2_apple_hit", {31'd0, a}, 32'd1);
    query(8'hC3, a); check("t2_old_gone", {31'd0, a}, 32'd0);

    // 3: only legal cell walled off -> failure.
    walls[0] = 8'h55;
    eat(4'b0001);
    wait_slot("t3", f);
    check("t3_fail_pulses", f, 1);
    @(negedge clk);
    check("t3_fail_low", {31'd0, place_fail}, 32'd0);
    pulse_body(3);
    check("t3_valid", 32'(apple_valid), 32'h0);
    hits = 0;
    for (int c = 0; c < 256; c++) begin
      query(8'(c), a);
      if (a === 1'b1) hits++;
    end
    check("t3_apple_none", hits, 0);

    // 4: four slots with a snake on C3..C5.
    reset = 1'b1; apple_count = 3'd4;
    xmin = 4'd0; xmax = 4'd15; ymin = 4'd0; ymax = 4'd15;
    snake_len = 5'd3;
    sx[0] = 4'd3; sx[1] = 4'd4; sx[2] = 4'd5;
    sy[0] = 4'd12; sy[1] = 4'd12; sy[2] = 4'd12;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    f2 = 0;
    for (int s = 0; s < NA; s++) begin
      wait_slot("t4_init", f);
      f2 += f;
    end
    check("t4_nofail", f2, 0);
    pulse_body(3);
    check("t4_valid", 32'(apple_valid), 32'hF);
    dups = 0;
    for (int i = 0; i < NA; i++) begin
      old[i] = loc(i);
      check($sformatf("t4_legal%0d", i), {31'd0, legal_model(old[i])}, 32'd1);
      for (int k = i + 1; k < NA; k++) if (loc(i) == loc(k)) dups++;
    end
    check("t4_distinct", dups, 0);

    walls[1] = old[0];
    walls[2] = old[2];
    eat(4'b0101);
    wait_slot("t4_s0", f);
    pulse_body(3);
    check("t4_s0_moved", {31'd0, loc(0) != old[0]}, 32'd1);
    check("t4_s0_legal", {31'd0, legal_model(loc(0))}, 32'd1);
    check("t4_s2_waits", 32'(loc(2)), 32'(old[2]));
    wait_slot("t4_s2", f2);
    check("t4_resp_nofail", f + f2, 0);
    pulse_body(3);
    check("t4_s2_moved", {31'd0, loc(2) != old[2]}, 32'd1);
    check("t4_s2_legal", {31'd0, legal_model(loc(2))}, 32'd1);
    check("t4_s1_kept", 32'(loc(1)), 32'(old[1]));
    check("t4_s3_kept", 32'(loc(3)), 32'(old[3]));
    dups = 0;
    for (int i = 0; i < NA; i++)
      for (int k = i + 1; k < NA; k++) if (loc(i) == loc(k)) dups++;
    check("t4_distinct2", dups, 0);

    // 5: disable slots 2,3 while slot 3 is in service.
    for (int i = 0; i < NA; i++) cur[i] = loc(i);
    eat(4'b1000);
    f = 0;
    while (busy !== 1'b1 && f < 8) begin
      @(negedge clk);
      f++;
    end
    check("t5_busy", {31'd0, busy}, 32'd1);
    apple_count = 3'd2;
    @(negedge clk);
    check("t5_abort", {31'd0, busy}, 32'd0);
    check("t5_nofail", {31'd0, place_fail}, 32'd0);
    @(negedge clk);
    check("t5_stay_idle", {31'd0, busy}, 32'd0);
    pulse_body(3);
    check("t5_valid", 32'(apple_valid), 32'h3);
    check("t5_loc2", 32'(loc(2)), 32'h0);
    check("t5_loc3", 32'(loc(3)), 32'h0);
    check("t5_loc0", 32'(loc(0)), 32'(cur[0]));
    check("t5_loc1", 32'(loc(1)), 32'(cur[1]));
    query(cur[3], a); check("t5_apple_gone", {31'd0, a}, 32'd0);

    // 6: reset during the scan phase of a hopeless placement.
    xmin = 4'd5; xmax = 4'd5; ymin = 4'd5; ymax = 4'd5;
    eat(4'b0001);
    repeat (60) @(negedge clk);
    check("t6_in_scan", {31'd0, busy}, 32'd1);
    reset = 1'b1; apple_count = 3'd1; snake_len = 5'd0;
    xmin = 4'd0; xmax = 4'd15; ymin = 4'd0; ymax = 4'd15;
    for (int j = 0; j < NW; j++) walls[j] = 8'hFF;
    @(negedge clk);
    check("t6_rst_valid", 32'(apple_valid), 32'h0);
    check("t6_rst_locs", apple_locations, 32'h0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_fail", {31'd0, place_fail}, 32'd0);
    query(8'h55, a); check("t6_rst_apple", {31'd0, a}, 32'd0);
    reset = 1'b0;
    wait_slot("t6", f);
    check("t6_nofail", f, 0);
    pulse_body(3);
    check("t6_loc", 32'(loc(0)), 32'hC3);
    check("t6_valid", 32'(apple_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
